// File: rtl/range_multi.sv
// Multi-lane Collatz range sweeper: LANES iterators fill a RAM with sequence lengths
// for RAM_WORDS consecutive start values, tracking the maximum and overflow.
module range_multi #(
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4,
    parameter int LANES         = 4,
    parameter int N_BITS        = 32,
    parameter int COUNT_BITS    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [N_BITS-1:0]        start,
    output logic                     busy,
    output logic                     done,
    output logic [COUNT_BITS-1:0]    count,
    output logic [COUNT_BITS-1:0]    max_count,
    output logic [RAM_ADDR_BITS-1:0] max_index,
    output logic                     overflow
);

    typedef enum logic [1:0] {L_IDLE, L_ITER, L_WAIT} lane_state_t;

    logic [COUNT_BITS-1:0]    mem [RAM_WORDS];
    logic                     busy_reg, done_reg, overflow_reg;
    logic [COUNT_BITS-1:0]    count_reg, max_count_reg;
    logic [RAM_ADDR_BITS-1:0] max_index_reg;
    logic [N_BITS-1:0]        base_reg;
    logic [RAM_ADDR_BITS:0]   wr_cnt_reg;
    logic                     accept;

    logic [LANES-1:0]         lane_wait, lane_ovf, grant;
    logic [RAM_ADDR_BITS-1:0] lane_idx [LANES];
    logic [COUNT_BITS-1:0]    lane_result [LANES];

    logic                     wr_en;
    logic [RAM_ADDR_BITS-1:0] wr_addr;
    logic [COUNT_BITS-1:0]    wr_data;

    assign accept = go && !busy_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        lane_state_t              state_reg;
        logic [N_BITS-1:0]        n_reg;
        logic [COUNT_BITS-1:0]    cnt_reg, result_reg;
        logic [RAM_ADDR_BITS-1:0] idx_reg;
        logic [N_BITS+1:0]        triple;
        logic [RAM_ADDR_BITS:0]   next_idx;
        logic                     has_next, term, bad;

        // 3n+1 computed two bits wider so the carry-out flags datapath overflow
        assign triple   = ({2'b00, n_reg} << 1) + {2'b00, n_reg} + (N_BITS+2)'(1);
        assign term     = (n_reg == N_BITS'(1));
        assign bad      = (n_reg == '0) || (n_reg[0] && (triple[N_BITS+1:N_BITS] != 2'b00));
        assign next_idx = {1'b0, idx_reg} + (RAM_ADDR_BITS+1)'(LANES);
        assign has_next = !next_idx[RAM_ADDR_BITS];

        assign lane_wait[gi]   = (state_reg == L_WAIT);
        assign lane_ovf[gi]    = (state_reg == L_ITER) && !term && bad;
        assign lane_idx[gi]    = idx_reg;
        assign lane_result[gi] = result_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_reg <= L_IDLE;
            end else begin
                case (state_reg)
                    L_IDLE: begin
                        if (accept) begin
                            state_reg <= L_ITER;
                            n_reg     <= start + N_BITS'(gi);
                            cnt_reg   <= COUNT_BITS'(1);
                            idx_reg   <= RAM_ADDR_BITS'(gi);
                        end
                    end
                    L_ITER: begin
                        if (term) begin
                            state_reg  <= L_WAIT;
                            result_reg <= cnt_reg;
                        end else if (bad) begin
                            state_reg  <= L_WAIT;
                            result_reg <= '1;
                        end else begin
                            n_reg   <= n_reg[0] ? triple[N_BITS-1:0] : (n_reg >> 1);
                            cnt_reg <= (&cnt_reg) ? cnt_reg : cnt_reg + COUNT_BITS'(1);
                        end
                    end
                    L_WAIT: begin
                        if (grant[gi]) begin
                            if (has_next) begin
                                state_reg <= L_ITER;
                                idx_reg   <= next_idx[RAM_ADDR_BITS-1:0];
                                n_reg     <= base_reg + N_BITS'(next_idx[RAM_ADDR_BITS-1:0]);
                                cnt_reg   <= COUNT_BITS'(1);
                            end else begin
                                state_reg <= L_IDLE;
                            end
                        end
                    end
                    default: state_reg <= L_IDLE;
                endcase
            end
        end
    end

    // Fixed priority: the lowest-numbered waiting lane owns the single write port
    always_comb begin
        grant   = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_wait[i] && !wr_en) begin
                grant[i] = 1'b1;
                wr_en    = 1'b1;
                wr_addr  = lane_idx[i];
                wr_data  = lane_result[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            max_count_reg <= '0;
            max_index_reg <= '0;
            wr_cnt_reg    <= '0;
        end else if (accept) begin
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            max_count_reg <= '0;
            max_index_reg <= '0;
            wr_cnt_reg    <= '0;
            base_reg      <= start;
        end else begin
            if (|lane_ovf) begin
                overflow_reg <= 1'b1;
            end
            if (wr_en) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
                if ((wr_data > max_count_reg) ||
                    ((wr_data == max_count_reg) && (wr_addr < max_index_reg))) begin
                    max_count_reg <= wr_data;
                    max_index_reg <= wr_addr;
                end
                if (wr_cnt_reg == (RAM_ADDR_BITS+1)'(RAM_WORDS-1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Readback shares the cycle budget with writes: a write cycle freezes count
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (!wr_en) begin
            count_reg <= mem[start[RAM_ADDR_BITS-1:0]];
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign overflow  = overflow_reg;
    assign count     = count_reg;
    assign max_count = max_count_reg;
    assign max_index = max_index_reg;

endmodule

// File: tb/tb_range_multi.sv
// Directed bench for range_multi: default lanes, 8-bit/16-lane and 1-lane/6-bit-count variants.
module tb_range_multi;

    logic        clk = 1'b0;
    logic        reset, go;
    logic [31:0] start;

    logic        a_busy, a_done, a_ovf;
    logic [15:0] a_count, a_max;
    logic [3:0]  a_maxi;
    logic        b_busy, b_done, b_ovf;
    logic [15:0] b_count, b_max;
    logic [3:0]  b_maxi;
    logic        c_busy, c_done, c_ovf;
    logic [5:0]  c_count, c_max;
    logic [3:0]  c_maxi;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] exp_tbl [16] = '{16'd1, 16'd2, 16'd8, 16'd3, 16'd6, 16'd9, 16'd17, 16'd4,
                                  16'd20, 16'd7, 16'd15, 16'd10, 16'd10, 16'd18, 16'd18, 16'd5};

    always #5 clk = ~clk;

    range_multi dut_a (
        .clk(clk), .reset(reset), .go(go), .start(start),
        .busy(a_busy), .done(a_done), .count(a_count), .max_count(a_max),
        .max_index(a_maxi), .overflow(a_ovf)
    );

    range_multi #(.N_BITS(8), .LANES(16)) dut_b (
        .clk(clk), .reset(reset), .go(go), .start(start[7:0]),
        .busy(b_busy), .done(b_done), .count(b_count), .max_count(b_max),
        .max_index(b_maxi), .overflow(b_ovf)
    );

    range_multi #(.LANES(1), .COUNT_BITS(6)) dut_c (
        .clk(clk), .reset(reset), .go(go), .start(start),
        .busy(c_busy), .done(c_done), .count(c_count), .max_count(c_max),
        .max_index(c_maxi), .overflow(c_ovf)
    );

    task automatic launch(input logic [31:0] s);
        start = s;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        $display("go start=%0d busy a/b/c=%0d/%0d/%0d", s, a_busy, b_busy, c_busy);
    endtask

    task automatic wait_done(output bit ok, output int ca, output int cc);
        int cyc = 0;
        ok = 1'b0;
        ca = -1;
        cc = -1;
        while (cyc < 3000) begin
            cyc++;
            @(posedge clk); #1;
            if (a_done && ca < 0) ca = cyc;
            if (c_done && cc < 0) cc = cyc;
            if (a_done && b_done && c_done) begin
                ok = 1'b1;
                break;
            end
        end
        $display("sweep end ok=%0d cycles a=%0d c=%0d", ok, ca, cc);
    endtask

    task automatic read_idx(input int k, output logic [15:0] ra, output logic [15:0] rb,
                            output logic [5:0] rc);
        start = 32'(k);
        @(posedge clk); #1;
        ra = a_count;
        rb = b_count;
        rc = c_count;
        $display("read idx=%0d a=%0d b=%0d c=%0d", k, ra, rb, rc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go = 1'b0;
        start = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if ({a_busy, a_done, a_ovf} !== 3'b000) $display("FAIL reset_flags got %b expected 000", {a_busy, a_done, a_ovf}); else pass_cnt++;
        total_cnt++; if (a_count !== 16'd0) $display("FAIL reset_count got %0d expected 0", a_count); else pass_cnt++;
        total_cnt++; if (a_max !== 16'd0 || a_maxi !== 4'd0) $display("FAIL reset_max got %0d/%0d expected 0/0", a_max, a_maxi); else pass_cnt++;
        total_cnt++; if ({b_busy, c_busy, b_done, c_done} !== 4'b0000) $display("FAIL reset_variants got %b expected 0000", {b_busy, c_busy, b_done, c_done}); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_default_sweep();
        bit ok;
        int ca, cc;
        logic [15:0] ra, rb;
        logic [5:0] rc;
        launch(32'd1);
        total_cnt++; if (a_busy !== 1'b1) $display("FAIL sweep_busy got %0d expected 1", a_busy); else pass_cnt++;
        wait_done(ok, ca, cc);
        total_cnt++; if (!ok) $display("FAIL sweep_timeout got %0d expected 1", ok); else pass_cnt++;
        for (int k = 0; k < 16; k++) begin
            read_idx(k, ra, rb, rc);
            total_cnt++; if (ra !== exp_tbl[k]) $display("FAIL sweep_a idx=%0d got %0d expected %0d", k, ra, exp_tbl[k]); else pass_cnt++;
            total_cnt++; if (rb !== exp_tbl[k]) $display("FAIL sweep_b idx=%0d got %0d expected %0d", k, rb, exp_tbl[k]); else pass_cnt++;
            total_cnt++; if (rc !== 6'(exp_tbl[k])) $display("FAIL sweep_c idx=%0d got %0d expected %0d", k, rc, exp_tbl[k]); else pass_cnt++;
        end
        total_cnt++; if (a_max !== 16'd20 || a_maxi !== 4'd8) $display("FAIL sweep_max_a got %0d/%0d expected 20/8", a_max, a_maxi); else pass_cnt++;
        total_cnt++; if (b_max !== 16'd20 || b_maxi !== 4'd8) $display("FAIL sweep_max_b got %0d/%0d expected 20/8", b_max, b_maxi); else pass_cnt++;
        total_cnt++; if (c_max !== 6'd20 || c_maxi !== 4'd8) $display("FAIL sweep_max_c got %0d/%0d expected 20/8", c_max, c_maxi); else pass_cnt++;
        total_cnt++; if ({a_ovf, b_ovf, c_ovf} !== 3'b000) $display("FAIL sweep_ovf got %b expected 000", {a_ovf, b_ovf, c_ovf}); else pass_cnt++;
        total_cnt++; if ({a_done, a_busy} !== 2'b10) $display("FAIL sweep_done got %b expected 10", {a_done, a_busy}); else pass_cnt++;
        total_cnt++; if (!(cc > ca)) $display("FAIL lane_speed got c=%0d a=%0d expected c>a", cc, ca); else pass_cnt++;
        read_idx(8, ra, rb, rc);
        total_cnt++; if (ra !== 16'd20) $display("FAIL readback_8 got %0d expected 20", ra); else pass_cnt++;
    endtask

    task automatic test_zero();
        bit ok;
        int ca, cc;
        logic [15:0] ra, rb;
        logic [5:0] rc;
        launch(32'd0);
        wait_done(ok, ca, cc);
        total_cnt++; if (!ok) $display("FAIL zero_timeout got %0d expected 1", ok); else pass_cnt++;
        read_idx(0, ra, rb, rc);
        total_cnt++; if (ra !== 16'hFFFF || rb !== 16'hFFFF) $display("FAIL zero_idx0 got %h/%h expected ffff/ffff", ra, rb); else pass_cnt++;
        total_cnt++; if (rc !== 6'd63) $display("FAIL zero_idx0_c got %0d expected 63", rc); else pass_cnt++;
        for (int k = 1; k < 16; k++) begin
            read_idx(k, ra, rb, rc);
            total_cnt++; if (ra !== exp_tbl[k-1]) $display("FAIL zero_a idx=%0d got %0d expected %0d", k, ra, exp_tbl[k-1]); else pass_cnt++;
        end
        total_cnt++; if ({a_ovf, b_ovf, c_ovf} !== 3'b111) $display("FAIL zero_ovf got %b expected 111", {a_ovf, b_ovf, c_ovf}); else pass_cnt++;
        total_cnt++; if (a_max !== 16'hFFFF || a_maxi !== 4'd0) $display("FAIL zero_max got %h/%0d expected ffff/0", a_max, a_maxi); else pass_cnt++;
    endtask

    task automatic test_handshake();
        bit ok;
        int ca, cc;
        logic [15:0] ra, rb;
        logic [5:0] rc;
        launch(32'd1);
        repeat (3) @(posedge clk);
        #1;
        launch(32'd100);
        total_cnt++; if ({a_busy, a_done} !== 2'b10) $display("FAIL ignored_go got %b expected 10", {a_busy, a_done}); else pass_cnt++;
        wait_done(ok, ca, cc);
        total_cnt++; if (!ok) $display("FAIL hs_timeout got %0d expected 1", ok); else pass_cnt++;
        for (int k = 0; k < 16; k++) begin
            read_idx(k, ra, rb, rc);
            total_cnt++; if (ra !== exp_tbl[k]) $display("FAIL hs_a idx=%0d got %0d expected %0d", k, ra, exp_tbl[k]); else pass_cnt++;
        end
        total_cnt++; if (a_max !== 16'd20 || a_maxi !== 4'd8) $display("FAIL hs_max got %0d/%0d expected 20/8", a_max, a_maxi); else pass_cnt++;
        total_cnt++; if (a_done !== 1'b1) $display("FAIL done_held got %0d expected 1", a_done); else pass_cnt++;
        // go after done doubles as the saturation and narrow-datapath overflow sweep
        launch(32'd27);
        total_cnt++; if ({a_busy, a_done} !== 2'b10) $display("FAIL rego_done got %b expected 10", {a_busy, a_done}); else pass_cnt++;
        wait_done(ok, ca, cc);
        total_cnt++; if (!ok) $display("FAIL rego_timeout got %0d expected 1", ok); else pass_cnt++;
        read_idx(0, ra, rb, rc);
        total_cnt++; if (ra !== 16'd112) $display("FAIL c27_a got %0d expected 112", ra); else pass_cnt++;
        total_cnt++; if (rb !== 16'hFFFF) $display("FAIL c27_b got %h expected ffff", rb); else pass_cnt++;
        total_cnt++; if (rc !== 6'd63) $display("FAIL c27_sat got %0d expected 63", rc); else pass_cnt++;
        total_cnt++; if ({a_ovf, b_ovf, c_ovf} !== 3'b010) $display("FAIL c27_ovf got %b expected 010", {a_ovf, b_ovf, c_ovf}); else pass_cnt++;
        total_cnt++; if (a_max !== 16'd112 || a_maxi !== 4'd0) $display("FAIL c27_max_a got %0d/%0d expected 112/0", a_max, a_maxi); else pass_cnt++;
        total_cnt++; if (c_max !== 6'd63 || c_maxi !== 4'd0) $display("FAIL c27_max_c got %0d/%0d expected 63/0", c_max, c_maxi); else pass_cnt++;
        total_cnt++; if (b_max !== 16'hFFFF || b_maxi !== 4'd0) $display("FAIL c27_max_b got %h/%0d expected ffff/0", b_max, b_maxi); else pass_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        bit ok;
        int ca, cc;
        logic [15:0] ra, rb;
        logic [5:0] rc;
        launch(32'd1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if ({a_busy, a_done, a_ovf} !== 3'b000) $display("FAIL midrst_flags got %b expected 000", {a_busy, a_done, a_ovf}); else pass_cnt++;
        total_cnt++; if (a_count !== 16'd0 || a_max !== 16'd0 || a_maxi !== 4'd0) $display("FAIL midrst_data got %0d/%0d/%0d expected 0/0/0", a_count, a_max, a_maxi); else pass_cnt++;
        reset = 1'b0;
        launch(32'd1);
        wait_done(ok, ca, cc);
        total_cnt++; if (!ok) $display("FAIL midrst_timeout got %0d expected 1", ok); else pass_cnt++;
        for (int k = 0; k < 16; k++) begin
            read_idx(k, ra, rb, rc);
            total_cnt++; if (ra !== exp_tbl[k]) $display("FAIL midrst_a idx=%0d got %0d expected %0d", k, ra, exp_tbl[k]); else pass_cnt++;
        end
        total_cnt++; if (a_max !== 16'd20 || a_maxi !== 4'd8) $display("FAIL midrst_max got %0d/%0d expected 20/8", a_max, a_maxi); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_default_sweep();
        test_zero();
        test_handshake();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/range_multi.md
# range_multi

Parametrised multi-lane successor to the single-iterator Collatz range sweeper. On `go`, it computes the Collatz sequence length for `RAM_WORDS` consecutive start values using `LANES` independent in-block iterators. It writes each result into an internal RAM, tracks the maximum count and its index, and serves registered readback through the same `start` port when idle. Widths, depth and lane count are parameters; count saturation, arithmetic-overflow detection and max tracking are new behaviour.

## Interface
- `RAM_WORDS`, 16, number of results stored; power of two.
- `RAM_ADDR_BITS`, 4, log2(`RAM_WORDS`).
- `LANES`, 4, parallel iterators; power of two, 1..`RAM_WORDS`.
- `N_BITS`, 32, width of start value and iterator datapath.
- `COUNT_BITS`, 16, width of stored counts.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `go` in 1: start a sweep; sampled only when `busy`=0.
- `start` in `N_BITS`: first value of the sweep when `go`=1. When idle, `start[RAM_ADDR_BITS-1:0]` is the readback index.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete; held until next accepted `go` or `reset`.
- `count` out `COUNT_BITS`: registered RAM readback.
- `max_count` out `COUNT_BITS`: largest count written this sweep.
- `max_index` out `RAM_ADDR_BITS`: index of `max_count`.
- `overflow` out 1: sticky; some value in this sweep hit datapath overflow or was 0.

## Operation
- **Definition:** `count(n)` is the number of terms from n to 1 inclusive. Examples: `count(1)`=1, `count(2)`=2, `count(3)`=8, `count(27)`=112.
- **Index mapping:** index k (0..`RAM_WORDS`-1) holds `count(start+k)`; the addition wraps mod 2^`N_BITS`. Lane i owns indices i, i+`LANES`, i+2·`LANES`, …
- **Lane states:**
  - IDLE → ITER on accepted `go`. Lane loads n=`start`+i, cnt=1.
  - ITER:
    - if n==1 → WAIT, result=cnt.
    - else if n==0 or 3n+1 ≥ 2^`N_BITS` (odd n) → WAIT, result=all-ones, set `overflow`.
    - else n ← even ? n>>1 : 3n+1. cnt ← cnt+1, saturating at all-ones. A saturated lane keeps iterating until it reaches 1 or overflows.
  - WAIT: request the write port. When granted, write mem[index]=result, then either load the lane's next index into ITER, or go to IDLE if none remain.
- **Write arbitration:** one RAM write per cycle; the lowest-numbered waiting lane wins. Others stay in WAIT.
- **Max update on each write:** replace if result > `max_count`, or result == `max_count` and index < `max_index`.
- **Completion:** on the edge performing the `RAM_WORDS`-th write, `busy`←0 and `done`←1.
- **Ignored `go`:** `go` while `busy`=1 is ignored.
- **Accepted `go`:** clears `done`, `max_count`, `max_index` and `overflow`, and sets `busy`.
- **Readback:** every cycle with no write, `count` ← mem[`start[RAM_ADDR_BITS-1:0]`]. During a write cycle `count` holds its value.
- **Reset:** all lanes IDLE. `busy`, `done`, `overflow`, `max_count`, `max_index` and `count` all go to 0. RAM contents are not cleared. Reset mid-sweep aborts the sweep; partially written RAM is left as is.

## Timing
- Edge E0 with `go`=1 and `busy`=0: lanes loaded; `busy`=1 after E0.
- A lane at n=1 detects termination on the next edge and enters WAIT. The earliest write is E2, i.e. `start`=1 with `LANES`≥1 writes index 0 at E2.
- After loading n, a lane spends `count(n)` ITER-evaluation cycles before WAIT, plus arbitration wait. A granted lane restarts ITER on the grant edge.
- Readback latency is 1 cycle: a write at edge Ew is visible on `count` after Ew+1, given a stable index and no write at Ew+1.
- `done` and `busy` change on the same edge as the final write; `max_count`/`max_index` are final after that edge.

## Test plan
- **Default sweep:** `LANES`=4, `start`=1 → indices 0..15 hold 1,2,8,3,6,9,17,4,20,7,15,10,10,18,18,5. Expect `max_count`=20, `max_index`=8, `overflow`=0, `done`=1. Then idle `start`=8 → `count`=20 one cycle later.
- **Lane-count independence:** repeat with `LANES`=1 and `LANES`=16 → identical RAM and max. `LANES`=1 takes strictly more cycles.
- **Zero and overflow:**
  - `start`=0 → index 0 = 0xFFFF, `overflow`=1, remaining indices hold `count(1..15)`.
  - `N_BITS`=8, `start`=27 → index 0 = all-ones, `overflow`=1.
- **Saturation:** `COUNT_BITS`=6, `start`=27 → index 0 = 63, `overflow`=0, `max_count`=63, `max_index`=0.
- **Handshake:** pulse `go` again mid-sweep with a different `start` → ignored, results match the first `start`. `go` after `done` → `done` drops next cycle, new sweep runs.
- **Reset mid-sweep:** assert `reset` during a sweep → all outputs 0 next cycle. A new `go` with `start`=1 completes correctly.
